// File: rtl/iomem_arbiter.sv
// Two-master round-robin arbiter for the PicoSoC iomem bus.
// A per-grant watchdog forces completion with ERR_DATA and records a sticky error.
module iomem_arbiter #(
   parameter int unsigned TIMEOUT  = 256,
   parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [3:0]  m0_wstrb,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   output logic [31:0] m0_rdata,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [3:0]  m1_wstrb,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   output logic [31:0] m1_rdata,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [3:0]  s_wstrb,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   input  logic [31:0] s_rdata,
   output logic [1:0]  grant,
   output logic        err,
   output logic        err_master,
   output logic [31:0] err_addr,
   input  logic        err_clr
);

   // state | meaning
   // IDLE  | no owner; pick next master round-robin (one cycle)
   // GRANT | owner's request passed through to the slave until done/timeout/abort
   typedef enum logic {IDLE, GRANT} state_t;

   localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

   state_t      state, state_nxt;
   logic        owner, owner_nxt;
   logic        last, last_nxt;
   logic [15:0] cnt, cnt_nxt;

   logic        in_grant;
   logic        own_valid;
   logic [31:0] own_addr;
   logic        timeout_hit;
   logic        done;
   logic [31:0] done_rdata;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         owner <= 1'b0;
         last  <= 1'b1;
         cnt   <= 16'd0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      in_grant    = (state == GRANT);
      own_valid   = owner ? m1_valid : m0_valid;
      own_addr    = owner ? m1_addr : m0_addr;
      timeout_hit = in_grant && own_valid && !s_ready && (cnt == CNT_LAST);
      done        = in_grant && (s_ready || timeout_hit);
      done_rdata  = timeout_hit ? ERR_DATA : s_rdata;

      grant    = 2'b00;
      s_valid  = 1'b0;
      s_addr   = 32'd0;
      s_wdata  = 32'd0;
      s_wstrb  = 4'd0;
      m0_ready = 1'b0;
      m1_ready = 1'b0;
      m0_rdata = 32'd0;
      m1_rdata = 32'd0;

      if (in_grant) begin
         grant   = owner ? 2'b10 : 2'b01;
         s_valid = own_valid && !timeout_hit;
         s_addr  = own_addr;
         s_wdata = owner ? m1_wdata : m0_wdata;
         s_wstrb = owner ? m1_wstrb : m0_wstrb;
         if (owner) begin
            m1_ready = done;
            m1_rdata = done ? done_rdata : 32'd0;
         end else begin
            m0_ready = done;
            m0_rdata = done ? done_rdata : 32'd0;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      cnt_nxt   = cnt;
      if (state == IDLE) begin
         cnt_nxt = 16'd0;
         if (m0_valid && m1_valid) begin
            owner_nxt = !last;
            state_nxt = GRANT;
         end else if (m0_valid || m1_valid) begin
            owner_nxt = m1_valid;
            state_nxt = GRANT;
         end
      end else begin
         cnt_nxt = cnt + 16'd1;
         if (done) begin
            state_nxt = IDLE;
            last_nxt  = owner;
         end else if (!own_valid) begin
            // master withdrew its request: abandon quietly, fairness history untouched
            state_nxt = IDLE;
         end
      end
   end

   // a timeout in the same cycle as err_clr must win
   always_ff @(posedge clk) begin
      if (reset) begin
         err        <= 1'b0;
         err_master <= 1'b0;
         err_addr   <= 32'd0;
      end else if (timeout_hit) begin
         err        <= 1'b1;
         err_master <= owner;
         err_addr   <= own_addr;
      end else if (err_clr) begin
         err        <= 1'b0;
         err_master <= 1'b0;
         err_addr   <= 32'd0;
      end
   end

endmodule

// File: doc/iomem_arbiter.md
Name: iomem_arbiter

Overview:
- Two-master, one-slave arbiter for the PicoSoC iomem peripheral bus (valid/ready, wstrb, addr, wdata, rdata).
- Master 0 is the CPU iomem port; master 1 is a secondary requester such as a DMA or audio engine. The slave side drives the board peripheral decode (GPIO/LED register at 0x03xxxxxx and others).
- Round-robin arbitration, one transfer per grant.
- A bus-timeout watchdog completes any hung transfer with an error word and latches the error.

Parameters:
- TIMEOUT, 256, cycles in GRANT without s_ready before forced completion; legal range 2..65535.
- ERR_DATA, 32'hDEADBEEF, rdata returned to the master on timeout.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- m0_valid  input  1  master 0 request; held until m0_ready
- m0_ready  output  1  master 0 completion, one-cycle pulse
- m0_wstrb  input  4  byte write strobes; 0 = read
- m0_addr  input  32  byte address
- m0_wdata  input  32  write data
- m0_rdata  output  32  read data, valid when m0_ready=1
- m1_valid, m1_ready, m1_wstrb, m1_addr, m1_wdata, m1_rdata: same widths and meanings for master 1
- s_valid  output  1  request to slave
- s_ready  input  1  slave completion pulse
- s_wstrb  output  4  muxed strobes
- s_addr  output  32  muxed address
- s_wdata  output  32  muxed write data
- s_rdata  input  32  slave read data
- grant  output  2  one-hot current owner; 00 when idle
- err  output  1  sticky timeout flag
- err_master  output  1  master that timed out
- err_addr  output  32  address of the timed-out transfer
- err_clr  input  1  clears err, err_master and err_addr

Behaviour:
- States: IDLE, GRANT. Registers:
  - state
  - owner (1 bit)
  - last (1 bit): last master served
  - cnt (16 bit)
  - error registers
- Reset values:
  - state=IDLE, last=1, so m0 has priority first
  - cnt=0, grant=00
  - err=0, err_master=0, err_addr=0
  - s_valid=0, m0_ready=0, m1_ready=0
  - s_addr, s_wdata, s_wstrb = 0 while idle; m*_rdata=0 when not ready
- IDLE:
  - If exactly one mX_valid is high, owner<=X and state<=GRANT.
  - If both are high, owner<=!last.
  - cnt<=0.
  - No outputs are asserted in IDLE; arbitration costs exactly 1 cycle.
- GRANT (all combinational pass-through from owner):
  - grant = one-hot(owner); s_valid = m[owner]_valid; s_addr/s_wdata/s_wstrb = m[owner] fields.
  - m[owner]_ready = s_ready; m[owner]_rdata = s_rdata.
  - The non-owner's ready is 0 and its rdata is 0.
  - Each cycle in GRANT, cnt<=cnt+1.
- GRANT exit conditions:
  - s_ready=1: state<=IDLE, last<=owner.
  - cnt==TIMEOUT-1 and s_ready=0 (forced completion): s_valid is forced to 0 in that cycle; m[owner]_ready=1 and m[owner]_rdata=ERR_DATA; err<=1, err_master<=owner, err_addr<=m[owner]_addr; state<=IDLE, last<=owner. Writes are dropped.
  - m[owner]_valid drops without ready (protocol abort): state<=IDLE, last unchanged, no ready pulse, no error.
- Minimum transfer latency:
  - Valid in cycle N at IDLE → s_valid at N+1.
  - A zero-wait slave completes at N+1, giving ready at N+1.
  - The next arbitration is at N+2; back-to-back transfers from one master take 2 cycles each.
- Simultaneous events:
  - s_ready in the timeout cycle: normal completion, no error.
  - err_clr in the same cycle as a new timeout: the new error wins (err=1, new fields).
  - Error fields are overwritten by each later timeout; err stays 1.
- Reset mid-GRANT:
  - Next cycle is IDLE with all outputs at reset values; the in-flight transfer is abandoned and no ready is issued.
- Fairness: under continuous requests from both masters, grants alternate strictly 0,1,0,1.

Test Plan:
- After reset, only m0 reads 0x03000000 and the slave answers with 0x000000A5 after 1 wait cycle → s_valid at cycle+1; m0_ready pulse at cycle+2 with rdata 0x000000A5; grant=01 then 00; err=0.
- m0 and m1 both valid in the same cycle after reset, zero-wait slave → m0 is served first, then m1; with continuous requests, grant sequence 01,00,10,00,01.
- m1 writes 0x12345678 with wstrb 0011 to 0x03000000 → slave sees the same addr/wdata/wstrb while grant=10; m0_ready stays 0 throughout.
- TIMEOUT=8, slave never responds to m1 at 0x03000010 → m1_ready pulses 8 cycles after grant; m1_rdata=0xDEADBEEF; s_valid=0 in that cycle; err=1, err_master=1, err_addr=0x03000010; err_clr pulse → err=0.
- s_ready arrives exactly at cnt==TIMEOUT-1 → normal rdata is returned, err stays 0.
- reset asserted while in GRANT with the slave stalled → next cycle grant=00, s_valid=0, no ready pulse; after reset release, m0 has priority.
